// File: rtl/mux_8_way_rr.sv
// Eight-channel valid/ready merge with round-robin arbitration into a registered
// output stage tagged with the source channel index.
module mux_8_way_rr #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_select
);

    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = 3;

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic [SEL_W-1:0] cand;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] words [N];

    // Unpack the flat input bus into per-channel words.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            words[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Rotating priority search starting at ptr; first valid channel wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr + SEL_W'(k);
            if (!grant_any && in_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

    // Ready depends only on the output register state and out_ready, never on the new word.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = reset ? '0 : (grant & {N{load_en}});
    assign xfer     = grant_any && load_en && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_select <= '0;
            ptr        <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= words[grant_idx];
            out_select <= grant_idx;
            ptr        <= grant_idx + SEL_W'(1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
